dmem_responder: RTL



---
 rtl/dmem_responder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with sequential dump port
// Optional read parity checking is enabled by defining DMEM_PARITY_EN.
module dmem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 256,
  parameter int DUMP_DEPTH = 128
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  DmemEn,
  input  logic                  DmemWrEn,
  input  logic [ADDR_WIDTH-1:0] Mem_Addr,
  input  logic [DATA_WIDTH-1:0] Data_Out,
  output logic [DATA_WIDTH-1:0] Data_In,
  input  logic                  Dump_Start,
  output logic                  Dump_Busy,
  output logic                  Dump_Valid,
  output logic [ADDR_WIDTH-1:0] Dump_Addr,
  output logic [DATA_WIDTH-1:0] Dump_Data,
  output logic                  Dump_Done,
  output logic                  Parity_Err
);

`ifdef DMEM_PARITY_EN
  localparam int LP_MEM_W = DATA_WIDTH + 1;
`else
  localparam int LP_MEM_W = DATA_WIDTH;
`endif
  localparam logic [ADDR_WIDTH:0] LP_LAST = (ADDR_WIDTH + 1)'(DUMP_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  logic [LP_MEM_W-1:0]   MEM [DEPTH];

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic [DATA_WIDTH-1:0] r_data_in;
  logic                  r_busy;
  logic                  r_valid;
  logic [ADDR_WIDTH-1:0] r_dump_addr;
  logic [DATA_WIDTH-1:0] r_dump_data;
  logic                  r_done;

  logic                  w_wr;
  logic                  w_rd;
  logic                  w_scan_rd;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [LP_MEM_W-1:0]   w_word;
  logic [LP_MEM_W-1:0]   w_wr_word;

  assign w_wr      = DmemEn && DmemWrEn;
  assign w_rd      = DmemEn && !DmemWrEn;
  // The scan only borrows the port on cycles the processor leaves idle.
  assign w_scan_rd = (r_state == S_SCAN) && !DmemEn;
  assign w_last    = w_scan_rd && (r_cnt == LP_LAST);
  assign w_addr    = DmemEn ? Mem_Addr : r_cnt[ADDR_WIDTH-1:0];
  assign w_word    = MEM[w_addr];

`ifdef DMEM_PARITY_EN
  assign w_wr_word = {^Data_Out, Data_Out};
`else
  assign w_wr_word = Data_Out;
`endif

  always_ff @(posedge Clock) begin
    if (w_wr) begin
      MEM[Mem_Addr] <= w_wr_word;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (Dump_Start) w_state_next = S_SCAN;
      S_SCAN:  if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_cnt       <= '0;
      r_data_in   <= '0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_dump_addr <= '0;
      r_dump_data <= '0;
      r_done      <= 1'b0;
    end else begin
      r_valid <= w_scan_rd;
      r_done  <= w_last;
      if (w_rd) begin
        r_data_in <= w_word[DATA_WIDTH-1:0];
      end
      if (w_scan_rd) begin
        r_dump_addr <= r_cnt[ADDR_WIDTH-1:0];
        r_dump_data <= w_word[DATA_WIDTH-1:0];
        r_cnt       <= r_cnt + 1'b1;
      end
      if ((r_state == S_IDLE) && Dump_Start) begin
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end
      if (r_state == S_DONE) begin
        r_busy <= 1'b0;
      end
    end
  end

`ifdef DMEM_PARITY_EN
  logic r_parity_err;

  // A word with consistent even parity XORs to zero across data and parity bit.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_parity_err <= 1'b0;
    end else if (w_rd) begin
      r_parity_err <= ^w_word;
    end
  end

  assign Parity_Err = r_parity_err;
`else
  assign Parity_Err = 1'b0;
`endif

  assign Data_In    = r_data_in;
  assign Dump_Busy  = r_busy;
  assign Dump_Valid = r_valid;
  assign Dump_Addr  = r_dump_addr;
  assign Dump_Data  = r_dump_data;
  assign Dump_Done  = r_done;

endmodule
